head_ptr_table: RTL and testbench

HEAD_PTR_TABLE -- requirements
Module: head_ptr_table

---
 rtl/head_ptr_table.sv | 214 +++++++++++++++++++++
 tb/tb_head_ptr_table.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/head_ptr_table.sv
// Head pointer table: hashes a task stream against a {ptr, val} RAM indexed by bucket
// and forwards each task, annotated with its bucket's head pointer, to the data table.
module head_ptr_table #(
   parameter int BUCKET_WIDTH  = 10,
   parameter int PTR_WIDTH     = 10,
   parameter int PAYLOAD_WIDTH = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_i,

   input  logic [PAYLOAD_WIDTH-1:0] task_i,
   input  logic [BUCKET_WIDTH-1:0]  task_bucket_i,
   input  logic                     task_valid_i,
   output logic                     task_ready_o,

   output logic [PAYLOAD_WIDTH-1:0] pdata_o,
   output logic [BUCKET_WIDTH-1:0]  pdata_bucket_o,
   output logic [PTR_WIDTH-1:0]     pdata_head_ptr_o,
   output logic                     pdata_head_ptr_val_o,
   output logic                     pdata_valid_o,
   input  logic                     pdata_ready_i,

   input  logic [BUCKET_WIDTH-1:0]  ht_wr_addr_i,
   input  logic [PTR_WIDTH-1:0]     ht_wr_data_ptr_i,
   input  logic                     ht_wr_data_ptr_val_i,
   input  logic                     ht_wr_en_i,

   input  logic                     clear_ram_run_i,
   output logic                     clear_ram_done_o
);

   localparam int DEPTH   = 1 << BUCKET_WIDTH;
   localparam int ENTRY_W = PTR_WIDTH + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic [BUCKET_WIDTH-1:0]   r_clr_cnt;
   logic [BUCKET_WIDTH-1:0]   w_clr_cnt_nxt;
   logic                      w_done_nxt;
   logic                      r_done;
   logic                      r_task_ready;

   logic [ENTRY_W-1:0]        r_mem [DEPTH];
   logic                      w_ram_we;
   logic [BUCKET_WIDTH-1:0]   w_ram_addr;
   logic [ENTRY_W-1:0]        w_ram_wdata;

   logic                      w_accept;
   logic                      r_s1_valid;
   logic [PAYLOAD_WIDTH-1:0]  r_s1_task;
   logic [BUCKET_WIDTH-1:0]   r_s1_bucket;
   logic                      w_fwd_hit;
   logic [ENTRY_W-1:0]        w_s1_entry;

   logic [PAYLOAD_WIDTH-1:0]  r_fifo_task   [4];
   logic [BUCKET_WIDTH-1:0]   r_fifo_bucket [4];
   logic [ENTRY_W-1:0]        r_fifo_entry  [4];
   logic [1:0]                r_wr_ptr;
   logic [1:0]                r_rd_ptr;
   logic [2:0]                r_count;
   logic [2:0]                w_count_nxt;
   logic                      w_push;
   logic                      w_pop;

   // Clear FSM: next state, clear address counter and done pulse
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_cnt_nxt = r_clr_cnt;
      w_done_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (clear_ram_run_i) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_cnt_nxt = '0;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt;
            end
         end
         ST_CLEAR: begin
            if (clear_ram_run_i) begin
               w_clr_cnt_nxt = '0;
            end else if (r_clr_cnt == {BUCKET_WIDTH{1'b1}}) begin
               w_state_nxt   = ST_IDLE;
               w_clr_cnt_nxt = '0;
               w_done_nxt    = 1'b1;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + BUCKET_WIDTH'(1);
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_clr_cnt_nxt = '0;
         end
      endcase
   end

   // FSM state, counter, done pulse and registered ready
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ST_IDLE;
         r_clr_cnt    <= '0;
         r_done       <= 1'b0;
         r_task_ready <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_clr_cnt    <= w_clr_cnt_nxt;
         r_done       <= w_done_nxt;
         // Credit check on next-cycle occupancy plus the task entering the RAM stage
         r_task_ready <= (w_state_nxt == ST_IDLE) &&
                         (({1'b0, w_count_nxt} + {3'b000, w_accept}) < 4'd4);
      end
   end

   // RAM write port: the clear sweep owns it in CLEAR, the engines otherwise
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_addr  = ht_wr_addr_i;
      w_ram_wdata = {ht_wr_data_ptr_i, ht_wr_data_ptr_val_i};
      if (r_state == ST_CLEAR) begin
         w_ram_we    = 1'b1;
         w_ram_addr  = r_clr_cnt;
         w_ram_wdata = '0;
      end else begin
         w_ram_we    = ht_wr_en_i;
      end
   end

   // Table storage, deliberately not reset
   always_ff @(posedge clk_i) begin
      if (w_ram_we) begin
         r_mem[w_ram_addr] <= w_ram_wdata;
      end
   end

   assign w_accept  = task_valid_i & r_task_ready;
   assign w_fwd_hit = ht_wr_en_i && (r_state == ST_IDLE) && (ht_wr_addr_i == r_s1_bucket);
   // A write landing this cycle is not yet visible in the array, so bypass it
   assign w_s1_entry = w_fwd_hit ? {ht_wr_data_ptr_i, ht_wr_data_ptr_val_i} : r_mem[r_s1_bucket];

   // RAM stage register: holds the accepted task while its bucket is read
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_s1_valid  <= 1'b0;
         r_s1_task   <= '0;
         r_s1_bucket <= '0;
      end else begin
         r_s1_valid  <= w_accept;
         if (w_accept) begin
            r_s1_task   <= task_i;
            r_s1_bucket <= task_bucket_i;
         end else begin
            r_s1_task   <= r_s1_task;
            r_s1_bucket <= r_s1_bucket;
         end
      end
   end

   assign w_push = r_s1_valid;
   assign w_pop  = (r_count != 3'd0) & pdata_ready_i;

   // FIFO occupancy bookkeeping
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + 3'd1;
         2'b01:   w_count_nxt = r_count - 3'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   // FIFO pointers and count
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         r_count  <= w_count_nxt;
         r_wr_ptr <= w_push ? r_wr_ptr + 2'd1 : r_wr_ptr;
         r_rd_ptr <= w_pop  ? r_rd_ptr + 2'd1 : r_rd_ptr;
      end
   end

   // FIFO storage; the entry slot doubles as the RAM output register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 4; i++) begin
            r_fifo_task[i]   <= '0;
            r_fifo_bucket[i] <= '0;
            r_fifo_entry[i]  <= '0;
         end
      end else if (w_push) begin
         r_fifo_task[r_wr_ptr]   <= r_s1_task;
         r_fifo_bucket[r_wr_ptr] <= r_s1_bucket;
         r_fifo_entry[r_wr_ptr]  <= w_s1_entry;
      end else begin
         r_fifo_task[r_wr_ptr]   <= r_fifo_task[r_wr_ptr];
      end
   end

   assign task_ready_o         = r_task_ready;
   assign clear_ram_done_o     = r_done;
   assign pdata_valid_o        = (r_count != 3'd0);
   assign pdata_o              = r_fifo_task[r_rd_ptr];
   assign pdata_bucket_o       = r_fifo_bucket[r_rd_ptr];
   assign pdata_head_ptr_o     = r_fifo_entry[r_rd_ptr][PTR_WIDTH:1];
   assign pdata_head_ptr_val_o = r_fifo_entry[r_rd_ptr][0];

endmodule

// File: tb/tb_head_ptr_table.sv
// Directed self-checking bench for head_ptr_table (16-bucket configuration).
module tb_head_ptr_table;

   localparam int BW = 4;
   localparam int PW = 10;
   localparam int DW = 64;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic [DW-1:0] task_i;
   logic [BW-1:0] task_bucket_i;
   logic          task_valid_i;
   logic          task_ready_o;
   logic [DW-1:0] pdata_o;
   logic [BW-1:0] pdata_bucket_o;
   logic [PW-1:0] pdata_head_ptr_o;
   logic          pdata_head_ptr_val_o;
   logic          pdata_valid_o;
   logic          pdata_ready_i;
   logic [BW-1:0] ht_wr_addr_i;
   logic [PW-1:0] ht_wr_data_ptr_i;
   logic          ht_wr_data_ptr_val_i;
   logic          ht_wr_en_i;
   logic          clear_ram_run_i;
   logic          clear_ram_done_o;

   int checks = 0;
   int errors = 0;

   head_ptr_table #(
      .BUCKET_WIDTH (BW),
      .PTR_WIDTH    (PW),
      .PAYLOAD_WIDTH(DW)
   ) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .task_i              (task_i),
      .task_bucket_i       (task_bucket_i),
      .task_valid_i        (task_valid_i),
      .task_ready_o        (task_ready_o),
      .pdata_o             (pdata_o),
      .pdata_bucket_o      (pdata_bucket_o),
      .pdata_head_ptr_o    (pdata_head_ptr_o),
      .pdata_head_ptr_val_o(pdata_head_ptr_val_o),
      .pdata_valid_o       (pdata_valid_o),
      .pdata_ready_i       (pdata_ready_i),
      .ht_wr_addr_i        (ht_wr_addr_i),
      .ht_wr_data_ptr_i    (ht_wr_data_ptr_i),
      .ht_wr_data_ptr_val_i(ht_wr_data_ptr_val_i),
      .ht_wr_en_i          (ht_wr_en_i),
      .clear_ram_run_i     (clear_ram_run_i),
      .clear_ram_done_o    (clear_ram_done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!task_ready_o && n < 50) begin
         step();
         n++;
      end
      chk(tag, 64'(task_ready_o), 64'd1);
   endtask

   task automatic ht_write(input int b, input logic [PW-1:0] p, input logic v);
      ht_wr_addr_i         = BW'(b);
      ht_wr_data_ptr_i     = p;
      ht_wr_data_ptr_val_i = v;
      ht_wr_en_i           = 1'b1;
      step();
      ht_wr_en_i           = 1'b0;
   endtask

   task automatic do_task(input string tag, input int b, input logic [DW-1:0] pl,
                          input logic [PW-1:0] eptr, input logic evld);
      wait_ready({tag, "_rdy"});
      task_i        = pl;
      task_bucket_i = BW'(b);
      task_valid_i  = 1'b1;
      step();
      task_valid_i  = 1'b0;
      chk({tag, "_lat1"}, 64'(pdata_valid_o), 64'd0);
      step();
      chk({tag, "_valid"}, 64'(pdata_valid_o), 64'd1);
      chk({tag, "_data"}, pdata_o, pl);
      chk({tag, "_bucket"}, 64'(pdata_bucket_o), 64'(b));
      chk({tag, "_ptr"}, 64'(pdata_head_ptr_o), 64'(eptr));
      chk({tag, "_val"}, 64'(pdata_head_ptr_val_o), 64'(evld));
      step();
   endtask

   initial begin
      logic [DW-1:0] exp_task [8];
      logic [BW-1:0] exp_b    [8];
      int            n;
      int            n_acc;
      int            leak;
      int            dflag;

      rst_i = 1'b1;
      task_i = '0; task_bucket_i = '0; task_valid_i = 1'b0;
      pdata_ready_i = 1'b1;
      ht_wr_addr_i = '0; ht_wr_data_ptr_i = '0; ht_wr_data_ptr_val_i = 1'b0; ht_wr_en_i = 1'b0;
      clear_ram_run_i = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_ready", 64'(task_ready_o), 64'd0);
      chk("rst_pvalid", 64'(pdata_valid_o), 64'd0);
      chk("rst_pdata", pdata_o, 64'd0);
      chk("rst_done", 64'(clear_ram_done_o), 64'd0);
      rst_i = 1'b0;
      step();
      chk("post_rst_ready", 64'(task_ready_o), 64'd1);

      // Full clear: 16 cycles not ready, then a single done pulse
      clear_ram_run_i = 1'b1;
      step();
      clear_ram_run_i = 1'b0;
      n = 0;
      while (!task_ready_o && n < 100) begin
         n++;
         step();
      end
      chk("clr_busy_cycles", 64'(n), 64'd16);
      chk("clr_done_pulse", 64'(clear_ram_done_o), 64'd1);
      step();
      chk("clr_done_once", 64'(clear_ram_done_o), 64'd0);

      // Every bucket reads back cleared
      for (int b = 0; b < 16; b++) begin
         do_task("sweep", b, 64'hC0DE_0000 + 64'(b), 10'h000, 1'b0);
      end

      // Written entry is returned two cycles after acceptance
      ht_write(5, 10'h02A, 1'b1);
      do_task("b5", 5, 64'h5555_AAAA_0000_0005, 10'h02A, 1'b1);

      // Same-cycle write then next-cycle write to the in-flight bucket
      wait_ready("fwd_rdy");
      task_i = 64'h7777; task_bucket_i = 4'd7; task_valid_i = 1'b1;
      ht_wr_addr_i = 4'd7; ht_wr_data_ptr_i = 10'h011; ht_wr_data_ptr_val_i = 1'b1; ht_wr_en_i = 1'b1;
      step();
      task_valid_i = 1'b0;
      ht_wr_data_ptr_i = 10'h012;
      chk("fwd_lat1", 64'(pdata_valid_o), 64'd0);
      step();
      ht_wr_en_i = 1'b0;
      chk("fwd_valid", 64'(pdata_valid_o), 64'd1);
      chk("fwd_ptr", 64'(pdata_head_ptr_o), 64'h012);
      chk("fwd_val", 64'(pdata_head_ptr_val_o), 64'd1);
      chk("fwd_data", pdata_o, 64'h7777);
      step();

      // Backpressure: credits limit acceptance to 4, order preserved
      pdata_ready_i = 1'b0;
      n_acc = 0;
      for (int i = 0; i < 10; i++) begin
         task_valid_i  = 1'b1;
         task_i        = 64'hA000 + 64'(i);
         task_bucket_i = (i % 2 == 0) ? 4'd5 : 4'd0;
         if (task_ready_o && n_acc < 8) begin
            exp_task[n_acc] = task_i;
            exp_b[n_acc]    = task_bucket_i;
            n_acc++;
         end
         step();
      end
      task_valid_i = 1'b0;
      chk("bp_accepted", 64'(n_acc), 64'd4);
      chk("bp_ready_low", 64'(task_ready_o), 64'd0);
      chk("bp_hold_valid", 64'(pdata_valid_o), 64'd1);
      chk("bp_hold_data0", pdata_o, exp_task[0]);
      step();
      chk("bp_hold_data1", pdata_o, exp_task[0]);
      pdata_ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("bp_out_valid", 64'(pdata_valid_o), 64'd1);
         chk("bp_out_data", pdata_o, exp_task[k]);
         chk("bp_out_bucket", 64'(pdata_bucket_o), 64'(exp_b[k]));
         chk("bp_out_ptr", 64'(pdata_head_ptr_o), (exp_b[k] == 4'd5) ? 64'h02A : 64'h000);
         step();
      end
      chk("bp_drained", 64'(pdata_valid_o), 64'd0);

      // Task in flight across a clear keeps its pre-clear entry
      ht_write(0, 10'h033, 1'b1);
      wait_ready("ic_rdy");
      task_i = 64'h0C0C; task_bucket_i = 4'd0; task_valid_i = 1'b1;
      clear_ram_run_i = 1'b1;
      step();
      clear_ram_run_i = 1'b0;
      task_i = 64'h0BAD;
      chk("ic_ready_low", 64'(task_ready_o), 64'd0);
      step();
      chk("ic_valid", 64'(pdata_valid_o), 64'd1);
      chk("ic_ptr", 64'(pdata_head_ptr_o), 64'h033);
      chk("ic_val", 64'(pdata_head_ptr_val_o), 64'd1);
      chk("ic_data", pdata_o, 64'h0C0C);
      n = 0;
      leak = 0;
      while (!task_ready_o && n < 100) begin
         step();
         n++;
         if (pdata_valid_o) leak++;
      end
      task_valid_i = 1'b0;
      chk("ic_no_accept", 64'(leak), 64'd0);
      chk("ic_done", 64'(clear_ram_done_o), 64'd1);
      do_task("ic_after", 0, 64'h0D0D, 10'h000, 1'b0);

      // Reset in the middle of a clear
      wait_ready("rc_rdy");
      clear_ram_run_i = 1'b1;
      step();
      clear_ram_run_i = 1'b0;
      step();
      step();
      step();
      rst_i = 1'b1;
      #1;
      chk("rc_ready", 64'(task_ready_o), 64'd0);
      chk("rc_pvalid", 64'(pdata_valid_o), 64'd0);
      chk("rc_done", 64'(clear_ram_done_o), 64'd0);
      chk("rc_pdata", pdata_o, 64'd0);
      chk("rc_bucket", 64'(pdata_bucket_o), 64'd0);
      chk("rc_ptr", 64'(pdata_head_ptr_o), 64'd0);
      chk("rc_val", 64'(pdata_head_ptr_val_o), 64'd0);
      step();
      rst_i = 1'b0;
      dflag = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (clear_ram_done_o) dflag++;
      end
      chk("rc_no_done", 64'(dflag), 64'd0);
      chk("rc_idle_ready", 64'(task_ready_o), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
